// File: rtl/nn_pkg.sv
// Shared widths and FSM state encoding for the
// weight-update datapath.
package nn_pkg;

    localparam int NUM_W_D = 8;
    localparam int W_W_D   = 8;
    localparam int X_W_D   = 10;
    localparam int F_W_D   = 23;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERR,
        S_UPDATE,
        S_DONE
    } state_t;

endpackage

// File: rtl/backprop_update_if.sv
// Request/result bundle between a controller
// and the backprop weight-update engine.
interface backprop_update_if #(
    parameter int NUM_W = nn_pkg::NUM_W_D,
    parameter int W_W   = nn_pkg::W_W_D,
    parameter int X_W   = nn_pkg::X_W_D,
    parameter int F_W   = nn_pkg::F_W_D
);

    logic                   start_i;
    logic [F_W-1:0]         final_i;
    logic [3:0]             target_i;
    logic [NUM_W*X_W-1:0]   x_i;
    logic [NUM_W*W_W-1:0]   weights_i;
    logic [3:0]             lr_shift_i;
    logic                   busy_o;
    logic                   done_o;
    logic [NUM_W*W_W-1:0]   weights_o;
    logic [2:0]             idx_o;

    modport master (
        output start_i, final_i, target_i,
        output x_i, weights_i, lr_shift_i,
        input  busy_o, done_o, weights_o, idx_o
    );

    modport slave (
        input  start_i, final_i, target_i,
        input  x_i, weights_i, lr_shift_i,
        output busy_o, done_o, weights_o, idx_o
    );

endinterface

// File: rtl/bp_grad_lane.sv
// One weight update: grad = err*x, floor shift,
// subtract from the weight, clamp to unsigned range.
module bp_grad_lane #(
    parameter int W_W = 8,
    parameter int X_W = 10,
    parameter int F_W = 23
) (
    input  logic signed [F_W:0] err,
    input  logic [X_W-1:0]      x,
    input  logic [W_W-1:0]      w,
    input  logic [3:0]          lr,
    output logic [W_W-1:0]      w_new
);

    localparam int G_W = F_W + X_W + 2;
    localparam int D_W = G_W + 1;

    logic signed [G_W-1:0] e_ext;
    logic signed [G_W-1:0] x_ext;
    logic signed [G_W-1:0] grad;
    logic signed [G_W-1:0] delta;
    logic signed [D_W-1:0] delta_ext;
    logic signed [D_W-1:0] w_ext;
    logic signed [D_W-1:0] diff;
    logic signed [D_W-1:0] w_max;
    logic [4:0]            sh;

    assign e_ext     = err;
    assign x_ext     = {{(G_W-X_W){1'b0}}, x};
    assign grad      = e_ext * x_ext;
    assign sh        = 5'd7 + {1'b0, lr};
    assign delta     = grad >>> sh;
    assign delta_ext = delta;
    assign w_ext     = {{(D_W-W_W){1'b0}}, w};
    assign diff      = w_ext - delta_ext;
    assign w_max     = {{(D_W-W_W){1'b0}}, {W_W{1'b1}}};

    // clamp the full-width difference into [0, 2^W_W-1]
    always_comb begin
        w_new = diff[W_W-1:0];
        if (diff < 0)
            w_new = '0;
        else if (diff > w_max)
            w_new = '1;
    end

endmodule

// File: rtl/backprop_update.sv
// Sequential weight-update engine: one error term,
// then one weight per cycle through a shared lane.
module backprop_update
    import nn_pkg::*;
#(
    parameter int NUM_W = NUM_W_D,
    parameter int W_W   = W_W_D,
    parameter int X_W   = X_W_D,
    parameter int F_W   = F_W_D
) (
    input logic clk_i,
    input logic rst_i,
    backprop_update_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_W - 1);

    state_t                 state;
    logic [F_W-1:0]         fin;
    logic [3:0]             tgt;
    logic [NUM_W*X_W-1:0]   xs;
    logic [NUM_W*W_W-1:0]   ws;
    logic [3:0]             lr;
    logic signed [F_W:0]    err;
    logic signed [F_W:0]    err_c;
    logic [IDX_W-1:0]       idx;
    logic                   busy;
    logic                   done;
    logic [NUM_W*W_W-1:0]   wout;
    logic [W_W-1:0]         w_new;

    assign err_c = $signed({1'b0, fin})
                 - $signed({{(F_W-3){1'b0}}, tgt});

    bp_grad_lane #(
        .W_W (W_W),
        .X_W (X_W),
        .F_W (F_W)
    ) u_lane (
        .err   (err),
        .x     (xs[idx*X_W +: X_W]),
        .w     (ws[idx*W_W +: W_W]),
        .lr    (lr),
        .w_new (w_new)
    );

    // control FSM with registered status and result outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
            fin   <= '0;
            tgt   <= '0;
            xs    <= '0;
            ws    <= '0;
            lr    <= '0;
            err   <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            wout  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        fin   <= bus.final_i;
                        tgt   <= bus.target_i;
                        xs    <= bus.x_i;
                        ws    <= bus.weights_i;
                        lr    <= bus.lr_shift_i;
                        busy  <= 1'b1;
                        state <= S_ERR;
                    end
                end
                S_ERR: begin
                    err <= err_c;
                    idx <= '0;
                    if (err_c == '0) begin
                        wout  <= ws;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    wout[idx*W_W +: W_W] <= w_new;
                    if (idx == LAST) begin
                        idx   <= '0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o    = busy;
    assign bus.done_o    = done;
    assign bus.idx_o     = idx;
    assign bus.weights_o = wout;

endmodule

// File: tb/tb_backprop_update.sv
// Scoreboard bench for backprop_update: random and
// directed passes against an arithmetic reference.
module tb_backprop_update;

    localparam int NW = 8;
    localparam int WW = 8;
    localparam int XW = 10;
    localparam int FW = 23;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    backprop_update_if #(
        .NUM_W(NW), .W_W(WW), .X_W(XW), .F_W(FW)
    ) bus ();

    backprop_update #(
        .NUM_W(NW), .W_W(WW), .X_W(XW), .F_W(FW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [NW*WW-1:0] w;
        int               edge_n;
    } exp_t;

    exp_t sbq[$];
    exp_t got;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h",
                     name, act, req);
        end
    endtask

    function automatic logic [NW*WW-1:0] model(
        input logic [FW-1:0] f,
        input logic [3:0] t,
        input logic [NW*XW-1:0] x,
        input logic [NW*WW-1:0] w,
        input logic [3:0] lr);
        logic [NW*WW-1:0] r;
        longint e, xk, wk, g, d, nw;
        e = longint'(f) - longint'(t);
        r = w;
        if (e != 0) begin
            for (int k = 0; k < NW; k++) begin
                xk = longint'(x[k*XW +: XW]);
                wk = longint'(w[k*WW +: WW]);
                g  = e * xk;
                d  = g >>> (7 + int'(lr));
                nw = wk - d;
                if (nw < 0) nw = 0;
                if (nw > (1 << WW) - 1) nw = (1 << WW) - 1;
                r[k*WW +: WW] = nw[WW-1:0];
            end
        end
        return r;
    endfunction

    // monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.done_o) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                got = sbq.pop_front();
                chk("weights", 64'(bus.weights_o), 64'(got.w));
                chk("done_edge", 64'(cyc + 1), 64'(got.edge_n));
            end
        end
    end

    task automatic scramble_inputs();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        bus.x_i = r[NW*XW-1:0];
        r = {$urandom(), $urandom(), $urandom()};
        bus.weights_i = r[NW*WW-1:0];
        bus.final_i = FW'($urandom());
        bus.target_i = 4'($urandom());
        bus.lr_shift_i = 4'($urandom());
    endtask

    task automatic issue(input logic [FW-1:0] f,
                         input logic [3:0] t,
                         input logic [NW*XW-1:0] x,
                         input logic [NW*WW-1:0] w,
                         input logic [3:0] lr,
                         output int n, output bit zero);
        exp_t e;
        @(negedge clk);
        bus.final_i = f;
        bus.target_i = t;
        bus.x_i = x;
        bus.weights_i = w;
        bus.lr_shift_i = lr;
        bus.start_i = 1'b1;
        n = cyc + 1;
        zero = (longint'(f) == longint'(t));
        e.w = model(f, t, x, w, lr);
        e.edge_n = n + (zero ? 2 : NW + 2);
        sbq.push_back(e);
    endtask

    task automatic run_pass(input logic [FW-1:0] f,
                            input logic [3:0] t,
                            input logic [NW*XW-1:0] x,
                            input logic [NW*WW-1:0] w,
                            input logic [3:0] lr,
                            input int hold);
        int n;
        bit zero;
        int idx_exp;
        bit busy_exp;
        int wait_n;
        issue(f, t, x, w, lr, n, zero);
        for (int j = 0; j <= NW + 2; j++) begin
            @(negedge clk);
            if (j + 1 >= hold) bus.start_i = 1'b0;
            if (j == 0) scramble_inputs();
            if (zero) begin
                idx_exp = 0;
                busy_exp = (j <= 1);
            end else begin
                idx_exp = (j >= 1 && j <= NW) ? j - 1 : 0;
                busy_exp = (j <= NW + 1);
            end
            chk("idx", 64'(bus.idx_o), 64'(idx_exp));
            chk("busy", 64'(bus.busy_o), 64'(busy_exp));
        end
        wait_n = 0;
        while (sbq.size() != 0 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=%0d required=0",
                     sbq.size());
            sbq.delete();
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
        chk({tag, "_done"}, 64'(bus.done_o), 64'd0);
        chk({tag, "_idx"}, 64'(bus.idx_o), 64'd0);
        chk({tag, "_weights"}, 64'(bus.weights_o), 64'd0);
    endtask

    logic [NW*XW-1:0] xv;
    logic [NW*WW-1:0] wv;
    logic [95:0]      rr;
    logic [FW-1:0]    fv;
    int               nn;
    bit               zz;

    initial begin
        bus.start_i = 1'b0;
        bus.final_i = '0;
        bus.target_i = '0;
        bus.x_i = '0;
        bus.weights_i = '0;
        bus.lr_shift_i = '0;

        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 64'(bus.busy_o), 64'd0);
        chk("idle_done", 64'(bus.done_o), 64'd0);

        // err=8, x0=16, w0=100 -> w0=99
        rr = {$urandom(), $urandom(), $urandom()};
        xv = rr[NW*XW-1:0];
        wv = {$urandom(), $urandom()};
        xv[0 +: XW] = 10'd16;
        wv[0 +: WW] = 8'd100;
        run_pass(23'd10, 4'd2, xv, wv, 4'd0, 1);

        // large positive grad drives w3 to 0
        xv[3*XW +: XW] = 10'd255;
        wv[3*WW +: WW] = 8'd1;
        run_pass(23'd200, 4'd0, xv, wv, 4'd0, 1);

        // negative err: w1 clamps to 255, w2 floors to +1
        xv[1*XW +: XW] = 10'd128;
        wv[1*WW +: WW] = 8'd253;
        xv[2*XW +: XW] = 10'd1;
        wv[2*WW +: WW] = 8'd50;
        run_pass(23'd0, 4'd5, xv, wv, 4'd0, 1);

        // zero error: short pass, weights pass through
        run_pass(23'd3, 4'd3, xv, wv, 4'd7, 1);

        // start held through the whole pass and DONE
        run_pass(23'd37, 4'd1, xv, wv, 4'd2, NW + 3);
        chk("held_busy", 64'(bus.busy_o), 64'd0);
        run_pass(23'd20, 4'd9, xv, wv, 4'd1, 1);

        // async reset in the middle of UPDATE
        issue(23'd150, 4'd4, xv, wv, 4'd0, nn, zz);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("postreset_busy", 64'(bus.busy_o), 64'd0);
        run_pass(23'd150, 4'd4, xv, wv, 4'd0, 1);

        for (int i = 0; i < 20; i++) begin
            rr = {$urandom(), $urandom(), $urandom()};
            xv = rr[NW*XW-1:0];
            wv = {$urandom(), $urandom()};
            if (i % 3 == 0)
                fv = FW'($urandom());
            else
                fv = FW'($urandom_range(0, 60));
            run_pass(fv, 4'($urandom_range(0, 15)), xv, wv,
                     4'($urandom_range(0, 15)), 1);
        end

        repeat (4) @(negedge clk);
        chk("queue_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
